// File: rtl/led_shift_pkg.sv
// Shared types and default sizes for the LED bar sequencer.
package led_shift_pkg;

    // Default sizing for the 16-LED board variant.
    localparam int unsigned DEF_WIDTH       = 16;
    localparam int unsigned DEF_PRESCALE_W  = 8;
    localparam int unsigned DEF_READIN_BITS = 2;

    // Bar motion selected at start.
    typedef enum logic [1:0] {
        SHIFT_R = 2'd0,
        SHIFT_L = 2'd1,
        ROT_R   = 2'd2,
        ROT_L   = 2'd3
    } mode_t;

    // Sequencer control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/step_prescaler.sv
// Step prescaler: one tick every div+1 enabled cycles. div is read live, so a
// count already past a lowered div wraps round before it matches again.
module step_prescaler
    import led_shift_pkg::*;
#(
    parameter int unsigned PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] div,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] cnt_q;

    assign tick = en && (cnt_q == div);

    // Count enabled cycles; clr has priority over counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            if (cnt_q == div) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_shift_bar.sv
// LED bar sequencer: full bar shifted or rotated one place per prescaled step.
// Optional macro LEDSHIFT_AUTORELOAD_EN makes DONE transient: the bar reloads
// and runs again in the same mode the cycle after done.
module led_shift_bar
    import led_shift_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned PRESCALE_W  = DEF_PRESCALE_W,
    parameter int unsigned READIN_BITS = DEF_READIN_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  start,
    input  logic                  stop,
    input  logic [1:0]            mode,
    input  logic [PRESCALE_W-1:0] div,
    output logic [WIDTH-1:0]      led,
    output logic                  readin_en,
    output logic                  busy,
    output logic                  done
);

    state_t            state_q, state_d;
    mode_t             mode_q, mode_d;
    logic [WIDTH-1:0]  led_q, led_d;
    logic [WIDTH-1:0]  led_step;
    logic              done_q;
    logic              enter_done;
    logic              cnt_clr;
    logic              tick;
    logic              exit_lsb;

    step_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en && (state_q == RUN)),
        .clr  (cnt_clr),
        .div  (div),
        .tick (tick)
    );

    // Bar value after one step in the latched mode.
    always_comb begin
        led_step = led_q;
        unique case (mode_q)
            SHIFT_R: led_step = led_q >> 1;
            SHIFT_L: led_step = led_q << 1;
            ROT_R:   led_step = {led_q[0], led_q[WIDTH-1:1]};
            ROT_L:   led_step = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
            default: led_step = led_q;
        endcase
    end

    // Control FSM next state; start beats stop, and both beat a pending tick.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        led_d      = led_q;
        cnt_clr    = 1'b0;
        enter_done = 1'b0;
        if (start) begin
            state_d = RUN;
            mode_d  = mode_t'(mode);
            led_d   = '1;
            cnt_clr = 1'b1;
        end else if (stop) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (tick) begin
                        led_d = led_step;
                        // Rotations never empty, so only shifts can finish.
                        if ((mode_q == SHIFT_R || mode_q == SHIFT_L) && led_step == '0) begin
                            state_d    = DONE;
                            cnt_clr    = 1'b1;
                            enter_done = 1'b1;
                        end
                    end
                end
                DONE: begin
`ifdef LEDSHIFT_AUTORELOAD_EN
                    state_d = RUN;
                    led_d   = '1;
                    cnt_clr = 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    // State, mode latch, bar register and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= SHIFT_R;
            led_q   <= '1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            led_q   <= led_d;
            done_q  <= enter_done;
        end
    end

    // Read window spans the LEDs about to leave the bar.
    always_comb begin
        exit_lsb = (mode_q == SHIFT_R) || (mode_q == ROT_R);
        if (exit_lsb) begin
            readin_en = &led_q[READIN_BITS-1:0];
        end else begin
            readin_en = &led_q[WIDTH-1 -: READIN_BITS];
        end
    end

    assign led  = led_q;
    assign busy = (state_q == RUN);
    assign done = done_q;

endmodule

// File: tb/tb_led_shift_bar.sv
// Self-checking bench for led_shift_bar: directed scenarios then random traffic,
// every cycle compared against a behavioural model of the bar.
module tb_led_shift_bar;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  div = 8'd0;
    logic [15:0] led;
    logic        readin_en;
    logic        busy;
    logic        done;

    int checks = 0;
    int passes = 0;

    // Reference model state: bar value, 0 idle / 1 run / 2 done, step count, mode.
    int m_led = 16'hFFFF;
    int m_state = 0;
    int m_cnt = 0;
    int m_mode = 0;
    int m_done = 0;

    led_shift_bar #(
        .WIDTH       (16),
        .PRESCALE_W  (8),
        .READIN_BITS (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .div       (div),
        .led       (led),
        .readin_en (readin_en),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic int next_bar(input int v, input int md);
        case (md)
            0:       return v / 2;
            1:       return (v * 2) % 65536;
            2:       return v / 2 + (v % 2) * 32768;
            default: return (v * 2) % 65536 + v / 32768;
        endcase
    endfunction

    function automatic int exp_readin(input int v, input int md);
        if (md == 0 || md == 2) return ((v % 4) == 3) ? 1 : 0;
        return ((v / 16384) == 3) ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_update();
        m_done = 0;
        if (rst) begin
            m_led = 16'hFFFF; m_state = 0; m_cnt = 0; m_mode = 0;
        end else if (start) begin
            m_led = 16'hFFFF; m_mode = int'(mode); m_cnt = 0; m_state = 1;
        end else if (stop) begin
            m_state = 0; m_cnt = 0;
        end else if (m_state == 1) begin
            if (en) begin
                if (m_cnt == int'(div)) begin
                    m_cnt = 0;
                    m_led = next_bar(m_led, m_mode);
                    if (m_mode < 2 && m_led == 0) begin
                        m_state = 2; m_done = 1;
                    end
                end else begin
                    m_cnt = (m_cnt + 1) % 256;
                end
            end
        end
`ifdef LEDSHIFT_AUTORELOAD_EN
        else if (m_state == 2) begin
            m_led = 16'hFFFF; m_cnt = 0; m_state = 1;
        end
`endif
    endtask

    // One clock: model follows the edge, outputs compared 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        chk("led", led, m_led);
        chk("busy", busy, (m_state == 1) ? 1 : 0);
        chk("done", done, m_done);
        chk("readin_en", readin_en, exp_readin(m_led, m_mode));
    endtask

    initial begin
        int done_seen;
        int busy_low;
        int readin_low;

        // Reset and idle with en high.
        step(); step();
        rst = 1'b0;
        chk("rst_led", led, 16'hFFFF);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_readin", readin_en, 1);
        en = 1'b1;
        repeat (3) step();
        chk("idle_led", led, 16'hFFFF);

        // SHIFT_R, div 0.
        start = 1'b1; mode = 2'd0; div = 8'd0;
        step();
        start = 1'b0;
        chk("shr_start_led", led, 16'hFFFF);
        chk("shr_start_busy", busy, 1);
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 14) begin
                chk("shr_0003", led, 16'h0003);
                chk("shr_0003_readin", readin_en, 1);
            end
            if (i == 15) begin
                chk("shr_0001", led, 16'h0001);
                chk("shr_0001_readin", readin_en, 0);
            end
        end
        chk("shr_empty", led, 16'h0000);
        chk("shr_done", done, 1);
        chk("shr_busy_low", busy, 0);
        step();
        chk("shr_done_pulse", done, 0);
`ifdef LEDSHIFT_AUTORELOAD_EN
        chk("reload_led", led, 16'hFFFF);
        chk("reload_busy", busy, 1);
`else
        chk("hold_led", led, 16'h0000);
        chk("hold_busy", busy, 0);
`endif

        // SHIFT_L, div 3, en every other cycle.
        start = 1'b1; mode = 2'd1; div = 8'd3; en = 1'b1;
        step();
        start = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 140; i++) begin
            en = ~en;
            step();
            if (done === 1'b1) done_seen++;
        end
        chk("shl_done_count", done_seen, 1);
        en = 1'b1;

        // Preload to 0x00FF, then restart as ROT_R.
        start = 1'b1; mode = 2'd0; div = 8'd0;
        step();
        start = 1'b0;
        repeat (8) step();
        chk("preload_00ff", led, 16'h00FF);
        start = 1'b1; mode = 2'd2;
        step();
        start = 1'b0;
        chk("rot_reload", led, 16'hFFFF);
        done_seen = 0; busy_low = 0; readin_low = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (done !== 1'b0) done_seen++;
            if (busy !== 1'b1) busy_low++;
            if (readin_en !== 1'b1) readin_low++;
        end
        chk("rot_no_done", done_seen, 0);
        chk("rot_busy", busy_low, 0);
        chk("rot_readin", readin_low, 0);

        // Stop at 0x0FFF, then start and stop together.
        start = 1'b1; mode = 2'd0; div = 8'd0;
        step();
        start = 1'b0;
        repeat (4) step();
        chk("pre_stop", led, 16'h0FFF);
        stop = 1'b1;
        step();
        stop = 1'b0;
        repeat (2) step();
        chk("stop_led", led, 16'h0FFF);
        chk("stop_busy", busy, 0);
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chk("startstop_led", led, 16'hFFFF);
        chk("startstop_busy", busy, 1);

        // Reset mid-run.
        div = 8'd2;
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_led", led, 16'hFFFF);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_readin", readin_en, 1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            en    = ($urandom_range(0, 3) != 0);
            start = ($urandom_range(0, 59) == 0);
            stop  = ($urandom_range(0, 99) == 0);
            mode  = 2'($urandom_range(0, 3));
            rst   = ($urandom_range(0, 799) == 0);
            if ($urandom_range(0, 49) == 0) div = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 499) == 0) div = 8'($urandom_range(0, 15));
            step();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/led_shift_bar.md
# led_shift_bar

Parametrised LED bar sequencer; successor to the fixed 16-bit right-shift LED bar. It drives a `WIDTH`-bit LED register that starts full and shifts or rotates one position per step, with a programmable step prescaler, run-time mode selection and a start/stop control FSM. It raises `readin_en` while the exit-end LEDs are lit and pulses `done` when the bar empties. It sits between the board LED pins and the input-capture logic that uses `readin_en` as its read window.

## Interface
Reset is synchronous and active-high. The clock is `clk` and the reset is `rst`.

Parameters:
- `WIDTH`, 16, LED count (≥ `READIN_BITS`+1).
- `PRESCALE_W`, 8, width of step divider.
- `READIN_BITS`, 2, number of exit-end LEDs that must all be lit for `readin_en`.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `en`  in  1  step enable; low freezes prescaler and LEDs.
- `start`  in  1  pulse: reload bar to all ones, latch `mode`, clear prescaler, enter RUN.
- `stop`  in  1  pulse: enter IDLE; LEDs hold their current value.
- `mode`  in  2  0 SHIFT_R, 1 SHIFT_L, 2 ROT_R, 3 ROT_L; sampled only on `start`.
- `div`  in  `PRESCALE_W`  step every `div`+1 enabled cycles; read live.
- `led`  out  `WIDTH`  LED register.
- `readin_en`  out  1  exit-end `READIN_BITS` LEDs all 1.
- `busy`  out  1  state == RUN.
- `done`  out  1  one-cycle pulse on entry to DONE.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE: `start` goes to RUN.
  - RUN: `stop` goes to IDLE. A tick that produces all-zero `led` in a SHIFT mode goes to DONE.
  - DONE: `start` goes to RUN, `stop` goes to IDLE.
- Simultaneous `start` and `stop`: `start` wins.
- Tick:
  - Occurs when RUN and `en` and `cnt == div`. `cnt` then returns to 0.
  - Otherwise, if RUN and `en`, `cnt` increments.
  - `cnt` holds when `en` is low.
  - `cnt` clears on `start`, `stop`, and entry to DONE.
- Tick action by latched mode:
  - SHIFT_R: `led >> 1`, zero fill at the MSB.
  - SHIFT_L: `led << 1`, zero fill at the LSB.
  - ROT_R / ROT_L: rotate by 1. The bar never empties and never reaches DONE.
- Exit end: LSB side for SHIFT_R and ROT_R; MSB side for SHIFT_L and ROT_L.
- `readin_en` is combinational from `led` and the latched mode: the AND of the `READIN_BITS` exit-end bits. It is valid in every state, including IDLE after reset.
- `div` changes mid-count take effect on the next compare. If `cnt > div`, `cnt` counts up and wraps at 2^`PRESCALE_W` before matching. No tick is lost other than through that wrap.
- Reset mid-run: the next cycle presents reset values and any pending tick is discarded.

## Timing
- Reset values:
  - `led` = all ones, state IDLE, `cnt` = 0, latched mode SHIFT_R.
  - `busy` = 0, `done` = 0.
  - `readin_en` = 1, because all LEDs are lit.
- `start` at edge N:
  - `led` = all ones and `busy` = 1 from N+1.
  - First tick is at edge N+1+`div`, given continuous `en`.
- `led` updates on the tick edge. `readin_en` follows in the same cycle.
- Emptying tick at edge M: `led` = 0, `busy` = 0 and `done` = 1 in cycle M+1 only.
- SHIFT mode from full, `en` continuous: `led` = 0 after exactly `WIDTH` ticks, which is `WIDTH`×(`div`+1) cycles.

## Configuration
- `LEDSHIFT_AUTORELOAD_EN`
  - Defined: DONE is transient. The cycle after `done`, the FSM reloads `led` to all ones, clears `cnt` and re-enters RUN with the same mode. `busy` is low for one cycle. `stop` in that cycle goes to IDLE.
  - Undefined: DONE holds `led` = 0 until `start`, `stop` or `rst`.

## Structure
- Package `led_shift_pkg` contains:
  - `mode_t` enum (SHIFT_R, SHIFT_L, ROT_R, ROT_L).
  - `state_t` enum (IDLE, RUN, DONE).
  - The default-width localparams.
- Sub-module `step_prescaler`:
  - Parameter: `PRESCALE_W`.
  - Ports: `clk`, `rst`, `en`, `clr`, `div`, `tick`.
  - Holds `cnt` and the compare/tick logic.
- The top level holds the FSM, the mode latch, the shift/rotate datapath and the readin/done logic.

## Test plan
All scenarios use `WIDTH`=16, `READIN_BITS`=2.
- Reset → `led`=0xFFFF, `busy`=0, `done`=0, `readin_en`=1. `en` high without `start` → `led` unchanged.
- SHIFT_R, `div`=0, `en` continuous:
  - `led` steps 0xFFFF→0x7FFF→…→0x0003, with `readin_en`=1.
  - 0x0001 → `readin_en`=0.
  - 0x0000 → `done` high one cycle; `led` stays 0 (macro off).
- SHIFT_L, `div`=3, `en` toggled every other cycle: ticks every 4 enabled cycles (8 clocks). `readin_en` drops at 0x8000 and `done` fires after 16 ticks.
- ROT_R from 0xFFFF with `led` preloaded by shifting to 0x00FF before restart: restart reloads 0xFFFF. Rotation runs 64 ticks with no `done`, `busy`=1 throughout, `readin_en`=1.
- `stop` mid-SHIFT_R at 0x0FFF → `led` holds 0x0FFF and `busy`=0. `start` and `stop` in the same cycle → `led`=0xFFFF and `busy`=1.
- With `LEDSHIFT_AUTORELOAD_EN`: SHIFT_R with `div`=0 → after `done`, next cycle `led`=0xFFFF and `busy`=1. `rst` asserted mid-run → reset values next cycle.
